// File: rtl/imm_gen_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pkg
// Shared constants for the immediate generator stage: RV32I base opcodes,
// immediate format encodings (as reported on imm_fmt) and the format width.
// Optional feature macro used by the stage: IMM_GEN_PERF_EN.
// -----------------------------------------------------------------------------
package imm_gen_pkg;

    localparam int FMT_W = 3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S    = 3'd2;
    localparam logic [FMT_W-1:0] FMT_B    = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U    = 3'd4;
    localparam logic [FMT_W-1:0] FMT_J    = 3'd5;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Purely combinational RV32I immediate decoder. Selects the immediate format
// from the opcode, assembles the 32-bit immediate and sign-extends it from
// instr[31] to XLEN bits.
// Ports:
//   instr    in   32     raw instruction word
//   imm      out  XLEN   sign-extended immediate (0 for NONE)
//   imm_fmt  out  3      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//   illegal  out  1      opcode not recognised
// -----------------------------------------------------------------------------
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    output logic [XLEN-1:0]  imm,
    output logic [FMT_W-1:0] imm_fmt,
    output logic             illegal
);

    logic signed [31:0] raw;

    always_comb begin
        raw     = '0;
        imm_fmt = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                raw     = {instr[31:12], 12'b0};
                imm_fmt = FMT_U;
            end
            OPC_JAL: begin
                raw     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
                imm_fmt = FMT_J;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                raw     = {{20{instr[31]}}, instr[31:20]};
                imm_fmt = FMT_I;
            end
            OPC_BRANCH: begin
                raw     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
                imm_fmt = FMT_B;
            end
            OPC_STORE: begin
                raw     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                imm_fmt = FMT_S;
            end
            OPC_OP: begin
                raw     = '0;
                imm_fmt = FMT_NONE;
            end
            default: begin
                raw     = '0;
                imm_fmt = FMT_NONE;
                illegal = 1'b1;
            end
        endcase
        // Fill every bit with the sign first, then overlay the low word; this
        // works for XLEN=32 and XLEN=64 without a zero-width replication.
        imm       = {XLEN{raw[31]}};
        imm[31:0] = raw;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Immediate generator stage between decode and execute. Decodes the RV32I
// immediate, computes pc + imm, and presents the result through a registered
// valid/ready output backed by a one-entry skid register, so in_ready is a
// flop and the stage sustains one instruction per cycle under backpressure.
// Optional feature macro: IMM_GEN_PERF_EN adds saturating counters
// perf_accepted / perf_illegal.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready registered)
//   instr[31:0], pc       instruction and its address
//   out_valid/out_ready   downstream handshake
//   imm, imm_fmt          sign-extended immediate and its format
//   branch_target         pc + imm, wraps modulo 2^XLEN
//   illegal               opcode not recognised
//   perf_accepted/_illegal (IMM_GEN_PERF_EN only) accept counters
// -----------------------------------------------------------------------------
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [FMT_W-1:0] imm_fmt,
    output logic [XLEN-1:0]  branch_target,
    output logic             illegal
`ifdef IMM_GEN_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_accepted,
    output logic [PERF_W-1:0] perf_illegal
`endif
);

    logic [XLEN-1:0]  dec_imm;
    logic [FMT_W-1:0] dec_fmt;
    logic             dec_ill;
    logic [XLEN-1:0]  dec_tgt;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (instr),
        .imm     (dec_imm),
        .imm_fmt (dec_fmt),
        .illegal (dec_ill)
    );

    assign dec_tgt = pc + dec_imm;

    // Main output register M
    logic             m_vld_q, m_vld_d;
    logic [XLEN-1:0]  m_imm_q, m_imm_d;
    logic [FMT_W-1:0] m_fmt_q, m_fmt_d;
    logic [XLEN-1:0]  m_tgt_q, m_tgt_d;
    logic             m_ill_q, m_ill_d;

    // Skid register K
    logic             k_vld_q, k_vld_d;
    logic [XLEN-1:0]  k_imm_q, k_imm_d;
    logic [FMT_W-1:0] k_fmt_q, k_fmt_d;
    logic [XLEN-1:0]  k_tgt_q, k_tgt_d;
    logic             k_ill_q, k_ill_d;

    logic             in_ready_q, in_ready_d;

    logic accept;
    logic xfer;

    assign accept = in_valid && in_ready_q;
    assign xfer   = m_vld_q && out_ready;

    always_comb begin
        m_vld_d = m_vld_q;
        m_imm_d = m_imm_q;
        m_fmt_d = m_fmt_q;
        m_tgt_d = m_tgt_q;
        m_ill_d = m_ill_q;
        k_vld_d = k_vld_q;
        k_imm_d = k_imm_q;
        k_fmt_d = k_fmt_q;
        k_tgt_d = k_tgt_q;
        k_ill_d = k_ill_q;

        if (k_vld_q) begin
            // K full means in_ready is low, so only a drain into M can happen.
            if (xfer) begin
                m_imm_d = k_imm_q;
                m_fmt_d = k_fmt_q;
                m_tgt_d = k_tgt_q;
                m_ill_d = k_ill_q;
                k_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_vld_q || out_ready) begin
                m_vld_d = 1'b1;
                m_imm_d = dec_imm;
                m_fmt_d = dec_fmt;
                m_tgt_d = dec_tgt;
                m_ill_d = dec_ill;
            end else begin
                k_vld_d = 1'b1;
                k_imm_d = dec_imm;
                k_fmt_d = dec_fmt;
                k_tgt_d = dec_tgt;
                k_ill_d = dec_ill;
            end
        end else if (xfer) begin
            m_vld_d = 1'b0;
        end

        in_ready_d = !k_vld_d;
    end

    // Output stage: M and handshake control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld_q    <= 1'b0;
            m_imm_q    <= '0;
            m_fmt_q    <= FMT_NONE;
            m_tgt_q    <= '0;
            m_ill_q    <= 1'b0;
            k_vld_q    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_vld_q    <= m_vld_d;
            m_imm_q    <= m_imm_d;
            m_fmt_q    <= m_fmt_d;
            m_tgt_q    <= m_tgt_d;
            m_ill_q    <= m_ill_d;
            k_vld_q    <= k_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Skid payload is qualified by k_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        k_imm_q <= k_imm_d;
        k_fmt_q <= k_fmt_d;
        k_tgt_q <= k_tgt_d;
        k_ill_q <= k_ill_d;
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = m_vld_q;
    assign imm           = m_imm_q;
    assign imm_fmt       = m_fmt_q;
    assign branch_target = m_tgt_q;
    assign illegal       = m_ill_q;

`ifdef IMM_GEN_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    logic [PERF_W-1:0] perf_acc_q;
    logic [PERF_W-1:0] perf_ill_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_acc_q <= '0;
            perf_ill_q <= '0;
        end else if (accept) begin
            perf_acc_q <= sat_inc(perf_acc_q);
            if (dec_ill) begin
                perf_ill_q <= sat_inc(perf_ill_q);
            end
        end
    end

    assign perf_accepted = perf_acc_q;
    assign perf_illegal  = perf_ill_q;
`else
    logic unused_perf_w;
    assign unused_perf_w = ^PERF_W;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Directed bench for imm_gen_pipe (XLEN=32): decode of every format, pc-relative
// targets including wrap, skid-buffer backpressure ordering, and reset while
// both registers are full. Perf counters are checked when IMM_GEN_PERF_EN is set.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_fmt;
    logic [XLEN-1:0] branch_target;
    logic            illegal;
`ifdef IMM_GEN_PERF_EN
    logic [31:0]     perf_accepted;
    logic [31:0]     perf_illegal;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(XLEN), .PERF_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .pc            (pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .imm           (imm),
        .imm_fmt       (imm_fmt),
        .branch_target (branch_target),
        .illegal       (illegal)
`ifdef IMM_GEN_PERF_EN
        ,
        .perf_accepted (perf_accepted),
        .perf_illegal  (perf_illegal)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one cycle with out_ready high, then check M.
    task automatic send_chk(input string tag, input logic [31:0] ins, input logic [31:0] p,
                            input logic [31:0] e_imm, input logic [2:0] e_fmt,
                            input logic [31:0] e_tgt, input logic e_ill);
        in_valid = 1'b1;
        instr    = ins;
        pc       = p;
        step();
        in_valid = 1'b0;
        chk({tag, ".vld"}, 64'(out_valid), 64'd1);
        chk({tag, ".imm"}, 64'(imm), 64'(e_imm));
        chk({tag, ".fmt"}, 64'(imm_fmt), 64'(e_fmt));
        chk({tag, ".tgt"}, 64'(branch_target), 64'(e_tgt));
        chk({tag, ".ill"}, 64'(illegal), 64'(e_ill));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = 32'h0;
        pc        = '0;
        repeat (2) step();

        chk("rst.vld", 64'(out_valid), 64'd0);
        chk("rst.imm", 64'(imm), 64'd0);
        chk("rst.fmt", 64'(imm_fmt), 64'd0);
        chk("rst.tgt", 64'(branch_target), 64'd0);
        chk("rst.ill", 64'(illegal), 64'd0);

        rst_n = 1'b1;
        step();
        chk("rel.rdy", 64'(in_ready), 64'd1);
        chk("rel.vld", 64'(out_valid), 64'd0);

        // Decode of each format
        send_chk("lui",   32'h123450B7, 32'h0000_0000, 32'h1234_5000, 3'd4, 32'h1234_5000, 1'b0);
        send_chk("addi",  32'hFFF00093, 32'h0000_0040, 32'hFFFF_FFFF, 3'd1, 32'h0000_003F, 1'b0);
        send_chk("beq",   32'hFE000CE3, 32'h0000_0100, 32'hFFFF_FFF8, 3'd3, 32'h0000_00F8, 1'b0);
        send_chk("sw",    32'hFE20AE23, 32'h0000_0200, 32'hFFFF_FFFC, 3'd2, 32'h0000_01FC, 1'b0);
        send_chk("jal",   32'h0010006F, 32'h0000_1000, 32'h0000_0800, 3'd5, 32'h0000_1800, 1'b0);
        send_chk("jalr",  32'h00C08067, 32'h0000_0004, 32'h0000_000C, 3'd1, 32'h0000_0010, 1'b0);
        send_chk("lw",    32'h80002083, 32'h0000_0000, 32'hFFFF_F800, 3'd1, 32'hFFFF_F800, 1'b0);
        send_chk("auipc", 32'hFFFFF097, 32'h0000_2000, 32'hFFFF_F000, 3'd4, 32'h0000_1000, 1'b0);
        send_chk("op",    32'h002081B3, 32'h0000_0010, 32'h0000_0000, 3'd0, 32'h0000_0010, 1'b0);
        send_chk("bad",   32'h0000007F, 32'h0000_0020, 32'h0000_0000, 3'd0, 32'h0000_0020, 1'b1);
`ifdef IMM_GEN_PERF_EN
        chk("perf.acc", 64'(perf_accepted), 64'd10);
        chk("perf.ill", 64'(perf_illegal), 64'd1);
`endif
        step();
        chk("drain.vld", 64'(out_valid), 64'd0);

        // Backpressure: A->M, B->K, C held upstream, D follows
        out_ready = 1'b0;
        pc        = '0;
        in_valid  = 1'b1;
        instr     = 32'h00100093;
        step();
        chk("bp.a.vld", 64'(out_valid), 64'd1);
        chk("bp.a.imm", 64'(imm), 64'd1);
        chk("bp.a.rdy", 64'(in_ready), 64'd1);
        instr = 32'h00200093;
        step();
        chk("bp.b.rdy", 64'(in_ready), 64'd0);
        chk("bp.b.imm", 64'(imm), 64'd1);
        instr = 32'h00300093;
        step();
        chk("bp.hold.rdy", 64'(in_ready), 64'd0);
        chk("bp.hold.imm", 64'(imm), 64'd1);
        chk("bp.hold.vld", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp.out2.imm", 64'(imm), 64'd2);
        chk("bp.out2.rdy", 64'(in_ready), 64'd1);
        step();
        chk("bp.out3.imm", 64'(imm), 64'd3);
        instr = 32'h00400093;
        step();
        in_valid = 1'b0;
        chk("bp.out4.imm", 64'(imm), 64'd4);
        chk("bp.out4.vld", 64'(out_valid), 64'd1);
        step();
        chk("bp.empty.vld", 64'(out_valid), 64'd0);

        // Reset with M and K both full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00500093;
        step();
        instr = 32'h00600093;
        step();
        in_valid = 1'b0;
        chk("mid.full.rdy", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.rst.vld", 64'(out_valid), 64'd0);
        chk("mid.rst.imm", 64'(imm), 64'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mid.rel.rdy", 64'(in_ready), 64'd1);
        chk("mid.rel.vld", 64'(out_valid), 64'd0);
        step();
        chk("mid.stale.vld", 64'(out_valid), 64'd0);
        send_chk("post", 32'h123450B7, 32'h0000_0004, 32'h1234_5000, 3'd4, 32'h1234_5004, 1'b0);
`ifdef IMM_GEN_PERF_EN
        chk("perf.post.acc", 64'(perf_accepted), 64'd1);
        chk("perf.post.ill", 64'(perf_illegal), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
